// File: rtl/lane_align_pkg.sv
// Shared types and constants for the lane alignment controller.
// FSM state encodings, default fill symbols and counter width.
package lane_align_pkg;

  localparam int CNT_W = 4;

  localparam logic [7:0] COM_SYM_DEF  = 8'hBC;
  localparam logic [7:0] IDLE_SYM_DEF = 8'h7C;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCK   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

endpackage

// File: rtl/lane_gap_cnt.sv
// Counts consecutive empty byte slots while the lane is aligned and flags
// the slot that reaches LOSS_COUNT; a valid byte in that slot suppresses it.
module lane_gap_cnt
  import lane_align_pkg::*;
#(
  parameter int LOSS_COUNT = 3
) (
  input  logic clk_4f,
  input  logic reset_L,
  input  logic enable,
  input  logic byte_valid,
  output logic loss
);

  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(LOSS_COUNT - 1);

  logic [CNT_W-1:0] gap_cnt;

  // The stored count covers earlier empty slots, so the current empty slot
  // is the LOSS_COUNT-th one when the count already sits one below the limit.
  assign loss = enable && !byte_valid && (gap_cnt == LAST_GAP);

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      gap_cnt <= '0;
    end else if (!enable || byte_valid || loss) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lane_align_ctrl.sv
// Receive-lane alignment controller: COM-run lock, payload forwarding, loss/resync.
// Optional alignment-loss counter on err_count when LANE_ALIGN_ERR_CNT_EN is defined.
module lane_align_ctrl
  import lane_align_pkg::*;
#(
  parameter logic [7:0] COM_SYM    = COM_SYM_DEF,
  parameter logic [7:0] IDLE_SYM   = IDLE_SYM_DEF,
  parameter int         LOCK_COUNT = 4,
  parameter int         LOSS_COUNT = 3
) (
  input  logic       clk_4f,
  input  logic       reset_L,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic [1:0] state,
  output logic       resync
`ifdef LANE_ALIGN_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_COUNT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_d;
  logic             valid_d, active_d, resync_d;
  logic             loss;
  logic             is_com, is_idle;

  assign is_com  = (byte_in == COM_SYM);
  assign is_idle = (byte_in == IDLE_SYM);
  assign state   = state_q;

  lane_gap_cnt #(
    .LOSS_COUNT(LOSS_COUNT)
  ) u_gap_cnt (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .enable    (state_q == ST_ACTIVE),
    .byte_valid(byte_valid),
    .loss      (loss)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_out;
    valid_d  = 1'b0;
    resync_d = 1'b0;
    unique case (state_q)
      ST_RESET: state_d = ST_SEARCH;
      ST_SEARCH: begin
        if (byte_valid && is_com) begin
          cnt_d   = CNT_W'(1);
          state_d = (LOCK_COUNT == 1) ? ST_ACTIVE : ST_LOCK;
        end
      end
      ST_LOCK: begin
        // Empty slots leave the COM run intact; only a real non-COM byte breaks it.
        if (byte_valid) begin
          if (is_com) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == LOCK_LAST) state_d = ST_ACTIVE;
          end else begin
            cnt_d   = '0;
            state_d = ST_SEARCH;
          end
        end
      end
      ST_ACTIVE: begin
        if (byte_valid && !is_com && !is_idle) begin
          data_d  = byte_in;
          valid_d = 1'b1;
        end else if (loss) begin
          state_d  = ST_SEARCH;
          cnt_d    = '0;
          resync_d = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
    active_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
      resync    <= 1'b0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_out  <= data_d;
      valid_out <= valid_d;
      active    <= active_d;
      resync    <= resync_d;
    end
  end

`ifdef LANE_ALIGN_ERR_CNT_EN
  logic lost_align;

  assign lost_align = (state_d == ST_SEARCH) &&
                      ((state_q == ST_LOCK) || (state_q == ST_ACTIVE));

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      err_count <= '0;
    end else if (lost_align && (err_count != 8'hFF)) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lane_align_ctrl.sv
// Scoreboard bench for lane_align_ctrl: a run-length reference model queues
// expected per-cycle outputs and payload bytes; a monitor pops and compares.
module tb_lane_align_ctrl;

  localparam int         LOCK_N = 4;
  localparam int         LOSS_N = 3;
  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] IDL    = 8'h7C;

  logic       clk_4f     = 1'b0;
  logic       reset_L    = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in    = 8'h00;
  logic [7:0] data_out;
  logic       valid_out, active, resync;
  logic [1:0] state;
`ifdef LANE_ALIGN_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  lane_align_ctrl #(
    .COM_SYM   (COM),
    .IDLE_SYM  (IDL),
    .LOCK_COUNT(LOCK_N),
    .LOSS_COUNT(LOSS_N)
  ) dut (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .state     (state),
    .resync    (resync)
`ifdef LANE_ALIGN_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct {
    logic [1:0] st;
    logic       act;
    logic       vo;
    logic       rs;
    logic [7:0] d;
    logic [7:0] err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fwd_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  // Reference model: phase (0 reset,1 search,2 lock,3 active) plus run lengths.
  int         m_phase, com_run, gap_run, m_err;
  logic [7:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; com_run = 0; gap_run = 0; m_err = 0; m_data = 8'h00;
    exp_q.delete();
    fwd_q.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, output exp_t e);
    e.rs = 1'b0;
    e.vo = 1'b0;
    case (m_phase)
      0: m_phase = 1;
      1: if (v && b == COM) begin
           com_run = 1;
           m_phase = (com_run == LOCK_N) ? 3 : 2;
           gap_run = 0;
         end
      2: if (v) begin
           if (b == COM) begin
             com_run++;
             if (com_run == LOCK_N) begin m_phase = 3; gap_run = 0; end
           end else begin
             com_run = 0; m_phase = 1; m_err++;
           end
         end
      default: begin
        if (v) begin
          gap_run = 0;
          if (b != COM && b != IDL) begin
            e.vo = 1'b1; m_data = b; fwd_q.push_back(b);
          end
        end else begin
          gap_run++;
          if (gap_run == LOSS_N) begin
            m_phase = 1; com_run = 0; e.rs = 1'b1; m_err++;
          end
        end
      end
    endcase
    if (m_err > 255) m_err = 255;
    e.st  = 2'(m_phase);
    e.act = (m_phase == 3);
    e.d   = m_data;
    e.err = 8'(m_err);
  endtask

  // Drive one byte slot starting at a negedge; the DUT samples it at the next posedge.
  task automatic cycle(input logic v, input logic [7:0] b);
    exp_t e;
    byte_valid = v;
    byte_in    = b;
    model_step(v, b, e);
    exp_q.push_back(e);
    @(negedge clk_4f);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [7:0] fb;
    forever begin
      @(posedge clk_4f);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("state", 32'(state), 32'(e.st));
        check("active", 32'(active), 32'(e.act));
        check("valid_out", 32'(valid_out), 32'(e.vo));
        check("resync", 32'(resync), 32'(e.rs));
        check("data_out", 32'(data_out), 32'(e.d));
`ifdef LANE_ALIGN_ERR_CNT_EN
        check("err_count", 32'(err_count), 32'(e.err));
`endif
        if (e.vo && fwd_q.size() != 0) begin
          fb = fwd_q.pop_front();
          check("payload", 32'(data_out), 32'(fb));
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_valid_out"}, 32'(valid_out), 32'd0);
    check({tag, "_resync"}, 32'(resync), 32'd0);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
`ifdef LANE_ALIGN_ERR_CNT_EN
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
`endif
  endtask

  initial begin : stimulus
    int         mode;
    logic       v;
    logic [7:0] b;
    int         r;

    model_reset();
    #3;
    check_reset_outputs("por");
    @(negedge clk_4f);
    @(negedge clk_4f);
    reset_L = 1'b1;
    cycle(1'b0, 8'h00);

    // Lock on four COMs, then forward payload around fill bytes.
    repeat (LOCK_N) cycle(1'b1, COM);
    cycle(1'b1, 8'h11);
    cycle(1'b1, COM);
    cycle(1'b1, IDL);
    cycle(1'b1, 8'h22);
    // Two-slot gap then a byte keeps alignment; three empty slots lose it.
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h33);
    repeat (LOSS_N) cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    // Broken COM run restarts the search.
    cycle(1'b1, COM);
    cycle(1'b1, COM);
    cycle(1'b1, 8'h55);
    repeat (LOCK_N) cycle(1'b1, COM);
    repeat (LOSS_N) cycle(1'b0, 8'h00);
    // Gaps inside a COM run are ignored while locking.
    cycle(1'b1, COM); cycle(1'b0, 8'h00); cycle(1'b0, 8'h00);
    cycle(1'b1, COM); cycle(1'b1, COM); cycle(1'b0, 8'h00);
    cycle(1'b1, COM);
    cycle(1'b1, 8'h44);

    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 16 == 0) mode = int'($urandom_range(0, 3));
      case (mode)
        0: begin
          v = ($urandom_range(0, 9) != 0);
          b = COM;
        end
        1: begin
          v = ($urandom_range(0, 9) < 8);
          r = int'($urandom_range(0, 9));
          b = (r == 0) ? COM : (r == 1) ? IDL : 8'($urandom);
        end
        2: begin
          v = 1'($urandom_range(0, 1));
          b = 8'($urandom);
        end
        default: begin
          v = ($urandom_range(0, 3) != 0);
          b = ($urandom_range(0, 1) == 1) ? COM : 8'($urandom);
        end
      endcase
      cycle(v, b);
    end

    // Asynchronous reset while aligned, mid-cycle.
    repeat (LOCK_N) cycle(1'b1, COM);
    cycle(1'b1, 8'h5A);
    #2;
    reset_L = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    @(negedge clk_4f);
    reset_L = 1'b1;
    cycle(1'b0, 8'h00);
    repeat (LOCK_N) cycle(1'b1, COM);
    cycle(1'b1, 8'hA5);
    cycle(1'b0, 8'h00);

    repeat (2) @(negedge clk_4f);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
